// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the Galois LFSR generator/checker pair.
//   lfsr_state_e : checker FSM states, 2-bit encoding (IDLE/SEED/HUNT/LOCKED)
//   galois_next  : one Galois LFSR step for a width of up to LFSR_MAX_W bits
// -----------------------------------------------------------------------------
package lfsr_pkg;

  // Widest LFSR that galois_next can step. Callers zero-extend their state
  // and polynomial to this width and truncate the result back.
  localparam int unsigned LFSR_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEED   = 2'd1,
    HUNT   = 2'd2,
    LOCKED = 2'd3
  } lfsr_state_e;

  // One Galois step on the low 'width' bits of q:
  //   nxt[width-1] = q[0]
  //   nxt[i]       = q[i+1] ^ (poly[i] & q[0])   for i < width-1
  // Written with whole-vector shifts and masks so no bit index depends on the
  // run-time width. poly[width-1] has no effect, as on the generator side.
  function automatic logic [LFSR_MAX_W-1:0] galois_next(
    input logic [LFSR_MAX_W-1:0] q,
    input logic [LFSR_MAX_W-1:0] poly,
    input int unsigned           width
  );
    logic [LFSR_MAX_W-1:0] top_bit;
    logic [LFSR_MAX_W-1:0] low_mask;
    logic [LFSR_MAX_W-1:0] q_m;
    logic [LFSR_MAX_W-1:0] fb;
    top_bit  = LFSR_MAX_W'(1) << (width - 1);
    low_mask = top_bit - LFSR_MAX_W'(1);
    q_m      = q & (top_bit | low_mask);
    fb       = {LFSR_MAX_W{q_m[0]}} & ((poly & low_mask) | top_bit);
    return (q_m >> 1) ^ fb;
  endfunction

endpackage

// File: rtl/lfsr_sat_cnt.sv
// -----------------------------------------------------------------------------
// lfsr_sat_cnt
// Saturating up-counter with synchronous clear.
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset (count -> 0)
//   clr_i  : synchronous clear; an increment in the same cycle still counts,
//            so clear plus an increment of n leaves the count at n
//   inc_i  : amount to add this cycle (INC_W bits, 0 = hold)
//   cnt_o  : current count, sticks at all-ones instead of wrapping
// -----------------------------------------------------------------------------
module lfsr_sat_cnt #(
  parameter int unsigned W     = 16,
  parameter int unsigned INC_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [INC_W-1:0] inc_i,
  output logic [W-1:0]     cnt_o
);

  // One spare bit above the wider operand so the sum can never overflow
  // before the saturation compare.
  localparam int unsigned SUM_W = ((W > INC_W) ? W : INC_W) + 1;

  logic [W-1:0]     cnt_q;
  logic [SUM_W-1:0] base;
  logic [SUM_W-1:0] sum;

  // The clear only selects a zero base, so an increment arriving in the same
  // cycle is applied after the clear.
  always_comb begin
    base = clr_i ? '0 : SUM_W'(cnt_q);
    sum  = base + SUM_W'(inc_i);
  end

  // Register the count, clamping at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (sum > SUM_W'({W{1'b1}})) begin
      cnt_q <= '1;
    end else begin
      cnt_q <= sum[W-1:0];
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/lfsr_prbs_checker.sv
// -----------------------------------------------------------------------------
// lfsr_prbs_checker
// Self-synchronising checker for a Galois LFSR word stream. It seeds from the
// first non-zero word, hunts for LOCK_CNT consecutive correct successors, then
// runs a local flywheel LFSR and flags words that differ from it. LOSS_CNT
// consecutive bad words while locked drop back to SEED.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   en_i           checker enable; low forces IDLE (counters hold)
//   clr_i          synchronous clear of the counters only
//   valid_i        dat_i carries one LFSR word this cycle
//   dat_i          received word (DATA_WIDTH)
//   locked_o       high while in LOCKED
//   err_o          one-cycle pulse the cycle after a bad word while locked
//   err_cnt_o      saturating count of bad words while locked
//   word_cnt_o     saturating count of words checked while locked
//   state_o        FSM state for debug (IDLE=0, SEED=1, HUNT=2, LOCKED=3)
//   bit_err_cnt_o  only with LFSR_PRBS_BITERR_EN defined: saturating count of
//                  bit errors (popcount of received ^ expected) while locked
//
// Configuration macro: LFSR_PRBS_BITERR_EN adds the bit-error counter.
// DATA_WIDTH must be between 2 and lfsr_pkg::LFSR_MAX_W.
// -----------------------------------------------------------------------------
module lfsr_prbs_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] POLY      = '0,
  parameter int unsigned          LOCK_CNT   = 8,
  parameter int unsigned          LOSS_CNT   = 4,
  parameter int unsigned          CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  locked_o,
  output logic                  err_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic [CNT_WIDTH-1:0]  word_cnt_o,
`ifdef LFSR_PRBS_BITERR_EN
  output logic [CNT_WIDTH-1:0]  bit_err_cnt_o,
`endif
  output logic [1:0]            state_o
);

  lfsr_state_e           state_q, state_n;
  logic [DATA_WIDTH-1:0] exp_q, exp_n;
  logic [7:0]            match_q, match_n;
  logic [7:0]            miss_q, miss_n;
  logic                  err_q, err_n;
  logic                  word_inc;
  logic                  err_inc;

  logic [DATA_WIDTH-1:0] nxt_exp;
  logic                  hit;
  logic [8:0]            match_inc;
  logic [8:0]            miss_inc;

  // Successor of the current expected word, and whether the incoming word
  // equals it. Match/miss increments are one bit wider so the compare against
  // the thresholds cannot wrap.
  always_comb begin
    nxt_exp   = DATA_WIDTH'(galois_next(LFSR_MAX_W'(exp_q), LFSR_MAX_W'(POLY), DATA_WIDTH));
    hit       = (dat_i == nxt_exp);
    match_inc = {1'b0, match_q} + 9'd1;
    miss_inc  = {1'b0, miss_q} + 9'd1;
  end

  // Next-state logic. In HUNT the expected word follows the data (reseeding
  // on any mismatch); in LOCKED it free-runs as a flywheel and the data is
  // only compared, never loaded.
  always_comb begin
    state_n  = state_q;
    exp_n    = exp_q;
    match_n  = match_q;
    miss_n   = miss_q;
    err_n    = 1'b0;
    word_inc = 1'b0;
    err_inc  = 1'b0;

    if (!en_i) begin
      state_n = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_n = SEED;
        end
        SEED: begin
          // An all-zero word is the LFSR lockup state and cannot seed.
          if (valid_i && (dat_i != '0)) begin
            exp_n   = dat_i;
            match_n = '0;
            state_n = HUNT;
          end
        end
        HUNT: begin
          if (valid_i) begin
            if (hit) begin
              exp_n   = dat_i;
              match_n = match_inc[7:0];
              if (match_inc >= 9'(LOCK_CNT)) begin
                miss_n  = '0;
                state_n = LOCKED;
              end
            end else if (dat_i == '0) begin
              match_n = '0;
              state_n = SEED;
            end else begin
              exp_n   = dat_i;
              match_n = '0;
            end
          end
        end
        LOCKED: begin
          if (valid_i) begin
            exp_n    = nxt_exp;
            word_inc = 1'b1;
            if (hit) begin
              miss_n = '0;
            end else begin
              err_n   = 1'b1;
              err_inc = 1'b1;
              miss_n  = miss_inc[7:0];
              if (miss_inc >= 9'(LOSS_CNT)) begin
                state_n = SEED;
              end
            end
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State register; reset leaves the checker idle with no lock history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      exp_q   <= '0;
      match_q <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      exp_q   <= exp_n;
      match_q <= match_n;
      miss_q  <= miss_n;
      err_q   <= err_n;
    end
  end

  assign locked_o = (state_q == LOCKED);
  assign err_o    = err_q;
  assign state_o  = state_q;

  lfsr_sat_cnt #(
    .W     (CNT_WIDTH),
    .INC_W (1)
  ) u_err_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_i),
    .inc_i (err_inc),
    .cnt_o (err_cnt_o)
  );

  lfsr_sat_cnt #(
    .W     (CNT_WIDTH),
    .INC_W (1)
  ) u_word_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_i),
    .inc_i (word_inc),
    .cnt_o (word_cnt_o)
  );

`ifdef LFSR_PRBS_BITERR_EN
  localparam int unsigned PC_W = $clog2(DATA_WIDTH + 1);

  logic [PC_W-1:0] bit_inc;

  // Number of differing bits between the word and the flywheel prediction,
  // counted only for valid words while locked and enabled.
  always_comb begin
    bit_inc = '0;
    if (en_i && valid_i && (state_q == LOCKED)) begin
      bit_inc = PC_W'($countones(dat_i ^ nxt_exp));
    end
  end

  lfsr_sat_cnt #(
    .W     (CNT_WIDTH),
    .INC_W (PC_W)
  ) u_bit_err_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_i),
    .inc_i (bit_inc),
    .cnt_o (bit_err_cnt_o)
  );
`endif

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_prbs_checker
// Self-checking bench for lfsr_prbs_checker with DATA_WIDTH=4, POLY=4'b0011,
// LOCK_CNT=3, LOSS_CNT=2, CNT_WIDTH=3. A behavioural model tracks the checker
// state from the rules for each cycle; directed scenarios are followed by a
// randomized stream. Build with LFSR_PRBS_BITERR_EN to also check the
// bit-error counter.
// -----------------------------------------------------------------------------
module tb_lfsr_prbs_checker;

  localparam int         DW      = 4;
  localparam logic [3:0] POLY    = 4'b0011;
  localparam int         LOCK    = 3;
  localparam int         LOSS    = 2;
  localparam int         CW      = 3;
  localparam int         CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          clr;
  logic          valid;
  logic [DW-1:0] dat;
  logic          locked;
  logic          err;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] word_cnt;
  logic [1:0]    state;
`ifdef LFSR_PRBS_BITERR_EN
  logic [CW-1:0] bit_err_cnt;
`endif

  int checkCount = 0;
  int failCount  = 0;

  // Reference model: mode 0=IDLE 1=SEED 2=HUNT 3=LOCKED
  int mState   = 0;
  int mExp     = 0;
  int mMatch   = 0;
  int mMiss    = 0;
  int mErr     = 0;
  int mErrCnt  = 0;
  int mWordCnt = 0;
  int mBitCnt  = 0;

  // Position of the transmitter in its sequence
  int gen = 1;

  lfsr_prbs_checker #(
    .DATA_WIDTH (DW),
    .POLY       (POLY),
    .LOCK_CNT   (LOCK),
    .LOSS_CNT   (LOSS),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .clr_i         (clr),
    .valid_i       (valid),
    .dat_i         (dat),
    .locked_o      (locked),
    .err_o         (err),
    .err_cnt_o     (err_cnt),
    .word_cnt_o    (word_cnt),
`ifdef LFSR_PRBS_BITERR_EN
    .bit_err_cnt_o (bit_err_cnt),
`endif
    .state_o       (state)
  );

  always #5 clk = ~clk;

  // Galois step in arithmetic form: shift right, the old LSB re-enters at the
  // top, and if it was 1 the low taps of POLY are toggled.
  function automatic int modelNext(input int q);
    int lsb;
    lsb = q & 1;
    return ((q >> 1) | (lsb << (DW - 1))) ^ (lsb * (int'(POLY) & ((1 << (DW - 1)) - 1)));
  endfunction

  function automatic int popCount(input int v);
    int n;
    n = 0;
    for (int i = 0; i < DW; i++) n += (v >> i) & 1;
    return n;
  endfunction

  function automatic int satAdd(input int base, input int inc);
    return (base + inc > CNT_MAX) ? CNT_MAX : base + inc;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic modelStep(input bit r, input bit e, input bit c, input bit v, input int d);
    int errInc;
    int wordInc;
    int bitInc;
    int nx;
    errInc  = 0;
    wordInc = 0;
    bitInc  = 0;
    if (r) begin
      mState = 0; mExp = 0; mMatch = 0; mMiss = 0; mErr = 0;
      mErrCnt = 0; mWordCnt = 0; mBitCnt = 0;
      return;
    end
    mErr = 0;
    nx   = modelNext(mExp);
    if (!e) begin
      mState = 0;
    end else if (mState == 0) begin
      mState = 1;
    end else if (mState == 1) begin
      if (v && d != 0) begin
        mExp = d; mMatch = 0; mState = 2;
      end
    end else if (mState == 2) begin
      if (v) begin
        if (d == nx) begin
          mExp = d;
          mMatch++;
          if (mMatch >= LOCK) begin
            mState = 3; mMiss = 0;
          end
        end else if (d == 0) begin
          mMatch = 0; mState = 1;
        end else begin
          mExp = d; mMatch = 0;
        end
      end
    end else begin
      if (v) begin
        wordInc = 1;
        bitInc  = popCount(d ^ nx);
        if (d != nx) begin
          mErr = 1; errInc = 1; mMiss++;
          if (mMiss >= LOSS) mState = 1;
        end else begin
          mMiss = 0;
        end
        mExp = nx;
      end
    end
    if (c) begin
      mErrCnt = 0; mWordCnt = 0; mBitCnt = 0;
    end
    mErrCnt  = satAdd(mErrCnt, errInc);
    mWordCnt = satAdd(mWordCnt, wordInc);
    mBitCnt  = satAdd(mBitCnt, bitInc);
  endtask

  // Drive one cycle, advance the model, then compare every output 1 time unit
  // after the edge.
  task automatic applyStimulus(input bit r, input bit e, input bit c, input bit v, input int d);
    rst   = r;
    en    = e;
    clr   = c;
    valid = v;
    dat   = DW'(d);
    @(posedge clk);
    modelStep(r, e, c, v, d & ((1 << DW) - 1));
    #1;
    checkOutput("state", 32'(state), mState);
    checkOutput("locked", 32'(locked), (mState == 3) ? 1 : 0);
    checkOutput("err", 32'(err), mErr);
    checkOutput("err_cnt", 32'(err_cnt), mErrCnt);
    checkOutput("word_cnt", 32'(word_cnt), mWordCnt);
`ifdef LFSR_PRBS_BITERR_EN
    checkOutput("bit_err_cnt", 32'(bit_err_cnt), mBitCnt);
`endif
  endtask

  // Send the transmitter's current word (optionally corrupted), then step it.
  task automatic sendWord(input int mask, input bit c);
    applyStimulus(1'b0, 1'b1, c, 1'b1, gen ^ mask);
    gen = modelNext(gen);
  endtask

  initial begin
    int weird;
    int d;
    bit v;

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0);
    checkOutput("reset_state", 32'(state), 0);
    checkOutput("reset_err_cnt", 32'(err_cnt), 0);

    $display("[TB] enable, zero word in SEED");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 0);
    checkOutput("seed_zero_stays", 32'(state), 1);

    $display("[TB] lock on 0001,1011,1110,0111");
    gen = 1;
    for (int i = 0; i < 4; i++) sendWord(0, 1'b0);
    checkOutput("lock_locked", 32'(locked), 1);
    checkOutput("lock_err_cnt", 32'(err_cnt), 0);

    $display("[TB] single error");
    sendWord(4'b0100, 1'b0);
    checkOutput("single_err_pulse", 32'(err), 1);
    checkOutput("single_err_cnt", 32'(err_cnt), 1);
    checkOutput("single_still_locked", 32'(locked), 1);
`ifdef LFSR_PRBS_BITERR_EN
    checkOutput("single_bit_err_cnt", 32'(bit_err_cnt), 1);
`endif
    sendWord(0, 1'b0);
    checkOutput("flywheel_match", 32'(err), 0);

    $display("[TB] valid gaps");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0);
    sendWord(0, 1'b0);
    sendWord(0, 1'b0);
    checkOutput("gap_err_cnt", 32'(err_cnt), 1);

    $display("[TB] clear together with an error");
    sendWord(4'b0001, 1'b1);
    checkOutput("clr_with_err", 32'(err_cnt), 1);
    sendWord(0, 1'b0);

    $display("[TB] saturation");
    for (int i = 0; i < 9; i++) begin
      sendWord(4'b0001, 1'b0);
      sendWord(0, 1'b0);
    end
    checkOutput("err_cnt_sat", 32'(err_cnt), CNT_MAX);
    checkOutput("word_cnt_sat", 32'(word_cnt), CNT_MAX);

    $display("[TB] loss of lock");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 0);
    sendWord(4'b0010, 1'b0);
    sendWord(4'b1000, 1'b0);
    checkOutput("loss_state", 32'(state), 1);
    checkOutput("loss_locked", 32'(locked), 0);
    checkOutput("loss_err_cnt", 32'(err_cnt), 2);

    $display("[TB] hunt reseed");
    sendWord(0, 1'b0);
    sendWord(0, 1'b0);
    weird = 4'b0101;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, weird);
    gen = modelNext(weird);
    sendWord(0, 1'b0);
    sendWord(0, 1'b0);
    checkOutput("reseed_still_hunt", 32'(state), 2);
    sendWord(0, 1'b0);
    checkOutput("reseed_relock", 32'(locked), 1);

    $display("[TB] reset while locked");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, gen);
    checkOutput("midrst_state", 32'(state), 0);
    checkOutput("midrst_word_cnt", 32'(word_cnt), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0);
    gen = 1;
    for (int i = 0; i < 4; i++) sendWord(0, 1'b0);
    checkOutput("relock_after_rst", 32'(locked), 1);

    $display("[TB] disable");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, gen);
    checkOutput("disable_idle", 32'(state), 0);
    checkOutput("disable_unlocked", 32'(locked), 0);

    $display("[TB] randomized stream");
    for (int i = 0; i < 2000; i++) begin
      bit r;
      bit e;
      bit c;
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 99) >= 3);
      c = ($urandom_range(0, 99) < 3);
      v = ($urandom_range(0, 99) < 75);
      d = gen;
      if (v) begin
        if ($urandom_range(0, 99) < 3) begin
          gen = int'($urandom_range(1, 15));
          d   = gen;
        end
        if ($urandom_range(0, 99) < 8) d = d ^ int'($urandom_range(1, 15));
        if ($urandom_range(0, 99) < 2) d = 0;
        gen = modelNext(gen);
      end
      applyStimulus(r, e, c, v, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/lfsr_prbs_checker.md
Name: lfsr_prbs_checker

Overview:
- Downstream consumer of a Galois LFSR word stream.
- Self-synchronises to the incoming sequence and, once locked, flags and counts word errors against a local flywheel LFSR.
- Used on test/loopback paths to check data that originated from the Galois generator.
- Expected sequence: one LFSR step per accepted word.

Parameters:
DATA_WIDTH, 32, LFSR state/word width (>=2)
POLY, '0 (DATA_WIDTH bits), Galois tap mask; same meaning as the generator's POLY
LOCK_CNT, 8, consecutive matches needed to declare lock (1..255)
LOSS_CNT, 4, consecutive mismatches while locked that drop lock (1..255)
CNT_WIDTH, 16, width of the error and word counters

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous active-high reset
en_i  in  1  checker enable; 0 forces IDLE
clr_i  in  1  synchronous clear of the counters only; FSM is unaffected
valid_i  in  1  dat_i carries one LFSR word this cycle
dat_i  in  DATA_WIDTH  received word
locked_o  out  1  high in LOCKED state
err_o  out  1  one-cycle pulse: mismatch detected while locked
err_cnt_o  out  CNT_WIDTH  saturating count of erroneous words while locked
word_cnt_o  out  CNT_WIDTH  saturating count of words checked while locked
state_o  out  2  FSM state encoding, for debug

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high on rst_i, sampled on the rising edge of clk_i.
- Reset values: state=IDLE, expected=0, match/miss counters=0, locked_o=0, err_o=0, err_cnt_o=0, word_cnt_o=0.
- Next-state function nxt(q):
  - nxt[DATA_WIDTH-1] = q[0].
  - For i < DATA_WIDTH-1: nxt[i] = q[i+1] ^ (POLY[i] & q[0]).
- States (2-bit encoding): IDLE=0, SEED=1, HUNT=2, LOCKED=3.
- IDLE:
  - Go to SEED when en_i=1.
  - en_i=0 in any state: next state is IDLE, locked_o drops next cycle, counters hold.
- SEED:
  - On valid_i with dat_i != 0: expected <= dat_i, match=0, go to HUNT.
  - An all-zero word is the lockup state: ignore it and stay in SEED.
- HUNT, on valid_i:
  - If dat_i == nxt(expected): expected <= dat_i and match++. When match reaches LOCK_CNT, go to LOCKED with miss=0.
  - Otherwise: reseed. expected <= dat_i, match=0, stay in HUNT. A zero word sends the FSM to SEED instead.
- LOCKED, on valid_i:
  - expected <= nxt(expected) always (flywheel; never reseeds from data). word_cnt++.
  - Match: miss=0.
  - Mismatch: err_o=1 next cycle, err_cnt++, miss++.
  - When miss reaches LOSS_CNT: go to SEED, locked_o=0.
- No valid_i: state, expected and counters hold; err_o=0.
- Latency: all outputs are registered. err_o and the counter updates appear on the cycle after the word is sampled. locked_o rises the cycle after the LOCK_CNT-th match.
- Counters:
  - Saturate at all-ones; no wrap.
  - clr_i zeroes both counters.
  - If clr_i and a counted event occur in the same cycle, the counter ends at 1 (the event counts after the clear).
- Priority: rst_i > en_i=0 > normal operation.
- Reset asserted mid-stream: lock is lost; the next enable resynchronises from SEED.

Optional Feature:
- LFSR_PRBS_BITERR_EN defined:
  - Adds output bit_err_cnt_o (CNT_WIDTH).
  - While LOCKED, each valid word adds popcount(dat_i ^ nxt(expected)) to it, saturating.
  - The counter is cleared by clr_i and reset.
- Undefined: the port and its logic are absent. Word-level behaviour is identical either way.

Decomposition:
- Package lfsr_pkg holds:
  - the state enum (IDLE/SEED/HUNT/LOCKED);
  - a galois_next function parameterised by width and POLY, shared with the generator side.
- Sub-module lfsr_sat_cnt: saturating counter with clr and inc inputs. It is instantiated twice, three times with LFSR_PRBS_BITERR_EN (that instance takes a multi-bit increment).

Test Plan:
- Sequence used below: DATA_WIDTH=4, POLY=4'b0011, LOCK_CNT=3, LOSS_CNT=2; the sequence runs 0001,1011,1110,0111.
- Lock: en_i=1, stream 0001,1011,1110,0111 with valid_i every cycle -> locked_o=1 one cycle after 0111; err_cnt_o=0.
- Single error: once locked, replace one word with expected^4'b0100 -> err_o pulses once, err_cnt_o=1, locked_o stays 1, and the following correct word matches (flywheel). With LFSR_PRBS_BITERR_EN, bit_err_cnt_o=1.
- Loss of lock: two consecutive wrong words while locked -> state_o=SEED, locked_o=0, err_cnt_o=2.
- Zero word / hunt reseed: in SEED feed 0000 -> stays SEED. In HUNT feed a non-sequence word -> match resets and a further LOCK_CNT matches are required.
- Valid gaps and counter edge cases:
  - Insert idle cycles in the locked stream -> no errors and no expected advance.
  - With CNT_WIDTH=2: force 5 errors -> err_cnt_o saturates at 3.
  - clr_i together with an error -> err_cnt_o=1.
- Reset and enable: assert rst_i while locked -> next cycle all outputs are at reset values. en_i=0 -> state_o=IDLE.
